miner_multicore_ctrl: RTL and testbench

Job controller for an N-core SHA-256d mining array.
- Accepts a job (midstate, 96-bit tail, nonce range, difficulty, mode) over a valid/ready handshake.
- Issues nonces to NUM_CORES hash cores in interleaved lanes and collects their hit reports.
- Filters hits against a runtime difficulty and queues golden nonces in a FIFO for the host interface.
- Replaces the single-core, fixed-difficulty, stop-the-clock control path with a multi-core, drain-aware, non-lossy one.

---
 rtl/miner_pkg.sv | 33 +++
 rtl/miner_multicore_ctrl_rr_arbiter.sv | 43 ++++
 rtl/miner_multicore_ctrl_sync_fifo.sv | 46 ++++
 rtl/miner_multicore_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_miner_multicore_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// Shared widths, SHA-256 constants, controller state encoding and hit-qualification
// helpers for the multicore miner control path.
package miner_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned HASH_W  = 32;
  localparam int unsigned DIFF_W  = 6;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] SHA256_LEN_HDR  = 32'h0000_0280;
  localparam logic [31:0] SHA256_LEN_HASH = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [DIFF_W-1:0] clamp_difficulty(input logic [DIFF_W-1:0] d);
    return (d > DIFF_W'(32)) ? DIFF_W'(32) : d;
  endfunction

  // Top d bits of hash word 7 must be zero; d=0 yields an empty mask.
  function automatic logic hit_qualifies(input logic [HASH_W-1:0] hash_hi,
                                         input logic [DIFF_W-1:0] d);
    logic [HASH_W-1:0] mask;
    mask = ~({HASH_W{1'b1}} >> d);
    return (hash_hi & mask) == '0;
  endfunction

endpackage

// File: rtl/miner_multicore_ctrl_rr_arbiter.sv
// Round-robin single grant across NUM_REQ requesters; pointer moves past the
// granted requester only when the grant is actually consumed.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               hash_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   pos;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(NUM_REQ)) pos = pos - (IDX_W + 1)'(NUM_REQ);
      if (!grant_valid && req[pos[IDX_W-1:0]]) begin
        grant_valid               = 1'b1;
        grant_idx                 = pos[IDX_W-1:0];
        grant[pos[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/miner_multicore_ctrl_sync_fifo.sv
// First-word fall-through FIFO; a pop in the same cycle frees a slot for a push when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             hash_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/miner_multicore_ctrl.sv
// Job controller for an N-core SHA-256d array: interleaved nonce issue, runtime
// difficulty filtering and a lossless golden-nonce queue toward the host.
module miner_multicore_ctrl
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned ISSUE_LOG2   = 1,
  parameter int unsigned DRAIN_CYCLES = 160,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned LANE_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        hash_clk,
  input  logic                        reset,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [255:0]                job_midstate,
  input  logic [95:0]                 job_data,
  input  logic [NONCE_W-1:0]          job_nonce_min,
  input  logic [NONCE_W-1:0]          job_nonce_max,
  input  logic [DIFF_W-1:0]           job_difficulty,
  input  logic                        job_stop_on_hit,
  input  logic                        job_abort,
  output logic [255:0]                core_midstate,
  output logic [95:0]                 core_data,
  output logic [NUM_CORES-1:0]        core_nonce_valid,
  output logic [NONCE_W*NUM_CORES-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]        core_hit_valid,
  input  logic [NONCE_W*NUM_CORES-1:0] core_hit_nonce,
  input  logic [HASH_W*NUM_CORES-1:0] core_hit_hash_hi,
  output logic [NUM_CORES-1:0]        core_hit_ready,
  output logic                        gn_valid,
  input  logic                        gn_ready,
  output logic [NONCE_W-1:0]          gn_nonce,
  output logic [LANE_W-1:0]           gn_core,
  output logic                        busy,
  output logic                        job_done,
  output logic [31:0]                 hashes_issued
);

  localparam int unsigned PERIOD  = 1 << ISSUE_LOG2;
  localparam int unsigned SLOT_W  = (ISSUE_LOG2 > 0) ? ISSUE_LOG2 : 1;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned GN_W    = NONCE_W + LANE_W;

  state_t              state;
  logic [32:0]         base;
  logic [NONCE_W-1:0]  nonce_max;
  logic [DIFF_W-1:0]   difficulty;
  logic                stop_on_hit;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic                accept, issue_slot, fire, push, gn_pop;
  logic                fifo_empty, fifo_full, grant_valid;
  logic [32:0]         cur_base, cur_max, lane_cnt, issued_sum;
  logic [32:0]         lane_nonce [NUM_CORES];
  logic [NUM_CORES-1:0] lane_ok, hit_qual, hit_drop, grant;
  logic [LANE_W-1:0]   grant_idx;
  logic [NONCE_W-1:0]  grant_nonce;
  logic [GN_W-1:0]     gn_dout;

  assign job_ready = (state == ST_IDLE);
  assign busy      = !job_ready;
  assign accept    = job_valid && job_ready;

  // The accept cycle issues straight from the job inputs so lanes appear at T+1.
  assign cur_base = job_ready ? {1'b0, job_nonce_min} : base;
  assign cur_max  = job_ready ? {1'b0, job_nonce_max} : {1'b0, nonce_max};

  always_comb begin
    lane_cnt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      lane_nonce[i] = cur_base + 33'(i);
      lane_ok[i]    = (lane_nonce[i] <= cur_max);
      lane_cnt      = lane_cnt + 33'(lane_ok[i]);
    end
  end

  assign issued_sum = (job_ready ? 33'd0 : {1'b0, hashes_issued}) + lane_cnt;

  assign issue_slot = (state == ST_RUN) && (slot_cnt == SLOT_W'(PERIOD - 1)) &&
                      (base <= {1'b0, nonce_max}) && !job_abort && !(stop_on_hit && push);
  assign fire       = (accept && (job_nonce_min <= job_nonce_max)) || issue_slot;

  always_comb begin
    hit_qual    = '0;
    hit_drop    = '0;
    grant_nonce = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      hit_qual[i] = core_hit_valid[i] && !job_ready &&
                    hit_qualifies(core_hit_hash_hi[HASH_W*i +: HASH_W], difficulty);
      hit_drop[i] = core_hit_valid[i] && !hit_qual[i];
      if (grant[i]) grant_nonce = grant_nonce | core_hit_nonce[NONCE_W*i +: NONCE_W];
    end
  end

  assign gn_valid       = !fifo_empty;
  assign gn_pop         = gn_valid && gn_ready;
  assign push           = grant_valid && (!fifo_full || gn_pop);
  assign core_hit_ready = hit_drop | (push ? grant : '0);
  assign gn_nonce       = gn_dout[NONCE_W-1:0];
  assign gn_core        = gn_dout[GN_W-1:NONCE_W];

  rr_arbiter #(
    .NUM_REQ (NUM_CORES),
    .IDX_W   (LANE_W)
  ) u_arb (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .req         (hit_qual),
    .advance     (push),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  sync_fifo #(
    .WIDTH (GN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_gn_fifo (
    .hash_clk (hash_clk),
    .reset    (reset),
    .push     (push),
    .din      ({grant_idx, grant_nonce}),
    .pop      (gn_pop),
    .dout     (gn_dout),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      base             <= '0;
      nonce_max        <= '0;
      difficulty       <= '0;
      stop_on_hit      <= 1'b0;
      slot_cnt         <= '0;
      drain_cnt        <= '0;
      core_midstate    <= '0;
      core_data        <= '0;
      core_nonce_valid <= '0;
      core_nonce       <= '0;
      hashes_issued    <= '0;
      job_done         <= 1'b0;
    end else begin
      core_nonce_valid <= '0;
      job_done         <= 1'b0;
      unique case (state)
        ST_IDLE: if (accept) begin
          core_midstate <= job_midstate;
          core_data     <= job_data;
          nonce_max     <= job_nonce_max;
          difficulty    <= clamp_difficulty(job_difficulty);
          stop_on_hit   <= job_stop_on_hit;
          base          <= {1'b0, job_nonce_min};
          hashes_issued <= '0;
          slot_cnt      <= '0;
          drain_cnt     <= '0;
          state         <= (job_nonce_min > job_nonce_max) ? ST_DRAIN : ST_RUN;
        end
        ST_RUN: begin
          if (job_abort) begin
            state <= ST_IDLE;
          end else if ((stop_on_hit && push) || (base > {1'b0, nonce_max})) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            slot_cnt <= (slot_cnt == SLOT_W'(PERIOD - 1)) ? '0 : slot_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (job_abort) begin
            state <= ST_IDLE;
          end else if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state    <= ST_IDLE;
            job_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Issue overrides the accept-time base/counter clear in the same cycle.
      if (fire) begin
        core_nonce_valid <= lane_ok;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          core_nonce[NONCE_W*i +: NONCE_W] <= lane_nonce[i][NONCE_W-1:0];
        end
        base          <= cur_base + 33'(NUM_CORES);
        hashes_issued <= issued_sum[32] ? '1 : issued_sum[31:0];
      end
    end
  end

endmodule

// File: tb/tb_miner_multicore_ctrl.sv
// Directed bench for miner_multicore_ctrl: issue timing, range edges, hit filtering,
// round-robin backpressure, stop-on-hit and abort.
module tb_miner_multicore_ctrl;

  localparam int unsigned NC    = 4;
  localparam int unsigned DRAIN = 20;

  logic            hash_clk = 1'b0;
  logic            reset;
  logic            job_valid, job_ready;
  logic [255:0]    job_midstate;
  logic [95:0]     job_data;
  logic [31:0]     job_nonce_min, job_nonce_max;
  logic [5:0]      job_difficulty;
  logic            job_stop_on_hit, job_abort;
  logic [255:0]    core_midstate;
  logic [95:0]     core_data;
  logic [NC-1:0]   core_nonce_valid;
  logic [32*NC-1:0] core_nonce;
  logic [NC-1:0]   core_hit_valid;
  logic [32*NC-1:0] core_hit_nonce, core_hit_hash_hi;
  logic [NC-1:0]   core_hit_ready;
  logic            gn_valid, gn_ready;
  logic [31:0]     gn_nonce;
  logic [1:0]      gn_core;
  logic            busy, job_done;
  logic [31:0]     hashes_issued;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 hash_clk = ~hash_clk;

  miner_multicore_ctrl #(
    .NUM_CORES    (NC),
    .ISSUE_LOG2   (1),
    .DRAIN_CYCLES (DRAIN),
    .FIFO_DEPTH   (2)
  ) dut (
    .hash_clk         (hash_clk),
    .reset            (reset),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_midstate     (job_midstate),
    .job_data         (job_data),
    .job_nonce_min    (job_nonce_min),
    .job_nonce_max    (job_nonce_max),
    .job_difficulty   (job_difficulty),
    .job_stop_on_hit  (job_stop_on_hit),
    .job_abort        (job_abort),
    .core_midstate    (core_midstate),
    .core_data        (core_data),
    .core_nonce_valid (core_nonce_valid),
    .core_nonce       (core_nonce),
    .core_hit_valid   (core_hit_valid),
    .core_hit_nonce   (core_hit_nonce),
    .core_hit_hash_hi (core_hit_hash_hi),
    .core_hit_ready   (core_hit_ready),
    .gn_valid         (gn_valid),
    .gn_ready         (gn_ready),
    .gn_nonce         (gn_nonce),
    .gn_core          (gn_core),
    .busy             (busy),
    .job_done         (job_done),
    .hashes_issued    (hashes_issued)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #2;
  endtask

  function automatic logic [31:0] lane_n(input int unsigned l);
    return core_nonce[32*l +: 32];
  endfunction

  task automatic start_job(input logic [31:0] nmin, input logic [31:0] nmax,
                           input logic [5:0] diff, input logic stop);
    job_nonce_min   = nmin;
    job_nonce_max   = nmax;
    job_difficulty  = diff;
    job_stop_on_hit = stop;
    job_valid       = 1'b1;
    tick();
    job_valid       = 1'b0;
  endtask

  task automatic set_hit(input int unsigned lane, input logic [31:0] nonce, input logic [31:0] hash);
    core_hit_valid[lane]          = 1'b1;
    core_hit_nonce[32*lane +: 32]   = nonce;
    core_hit_hash_hi[32*lane +: 32] = hash;
  endtask

  // Behaves like the cores: a hit leaves once the controller accepted it.
  task automatic step_cores();
    logic [NC-1:0] rdy;
    #1;
    rdy = core_hit_ready;
    tick();
    core_hit_valid = core_hit_valid & ~rdy;
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    int unsigned n = 0;
    while (!job_done && n < limit) begin
      tick();
      n++;
    end
    check(tag, job_done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic any_issue;
    reset = 1'b1;
    job_valid = 1'b0; job_abort = 1'b0; gn_ready = 1'b0;
    job_midstate = {8{32'hDEAD_BEEF}};
    job_data = 96'hC0FFEE_0011_2233_4455_6677;
    job_nonce_min = '0; job_nonce_max = '0; job_difficulty = '0; job_stop_on_hit = 1'b0;
    core_hit_valid = '0; core_hit_nonce = '0; core_hit_hash_hi = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_gn_valid", gn_valid, 1'b0);
    check("rst_nonce_valid", core_nonce_valid, 4'h0);
    check("rst_hashes", hashes_issued, 32'h0);
    check("rst_done", job_done, 1'b0);

    // Full-range job with three issues
    start_job(32'h10, 32'h1B, 6'd0, 1'b0);
    check("t1_valid0", core_nonce_valid, 4'hF);
    check("t1_lanes0", core_nonce, {32'h13, 32'h12, 32'h11, 32'h10});
    check("t1_data", core_data, 96'hC0FFEE_0011_2233_4455_6677);
    tick();
    check("t1_gap", core_nonce_valid, 4'h0);
    tick();
    check("t1_valid1", core_nonce_valid, 4'hF);
    check("t1_lanes1", core_nonce, {32'h17, 32'h16, 32'h15, 32'h14});
    tick(); tick();
    check("t1_valid2", core_nonce_valid, 4'hF);
    check("t1_lanes2", core_nonce, {32'h1B, 32'h1A, 32'h19, 32'h18});
    for (int i = 0; i < DRAIN; i++) tick();
    check("t1_done_early", job_done, 1'b0);
    check("t1_busy_drain", busy, 1'b1);
    tick();
    check("t1_done", job_done, 1'b1);
    check("t1_idle", busy, 1'b0);
    check("t1_hashes", hashes_issued, 32'd12);
    tick();
    check("t1_done_pulse", job_done, 1'b0);

    // Nonce range ending at 0xFFFFFFFF
    start_job(32'hFFFF_FFFD, 32'hFFFF_FFFF, 6'd0, 1'b0);
    check("t2_valid", core_nonce_valid, 4'b0111);
    check("t2_lane0", lane_n(0), 32'hFFFF_FFFD);
    check("t2_lane2", lane_n(2), 32'hFFFF_FFFF);
    tick(); tick();
    check("t2_no_reissue", core_nonce_valid, 4'h0);
    wait_done("t2_done", 100);
    check("t2_hashes", hashes_issued, 32'd3);

    // Stale hit while idle is dropped
    tick();
    set_hit(3, 32'h77, 32'h0);
    #1;
    check("idle_ready", core_hit_ready, 4'b1000);
    step_cores();
    tick();
    check("idle_no_push", gn_valid, 1'b0);

    // Difficulty 32: only the all-zero hash qualifies
    start_job(32'h0, 32'hFFFF, 6'd32, 1'b0);
    set_hit(1, 32'hAAA1, 32'h0000_0000);
    set_hit(2, 32'hAAA2, 32'h0000_0001);
    #1;
    check("t3_ready", core_hit_ready, 4'b0110);
    step_cores();
    check("t3_gn_valid", gn_valid, 1'b1);
    check("t3_gn_nonce", gn_nonce, 32'hAAA1);
    check("t3_gn_core", gn_core, 2'd1);
    gn_ready = 1'b1;
    tick();
    gn_ready = 1'b0;
    check("t3_single", gn_valid, 1'b0);
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    check("t3_abort_idle", busy, 1'b0);

    // Backpressure with a two-entry FIFO
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    start_job(32'h0, 32'hFFFF, 6'd8, 1'b0);
    for (int unsigned l = 0; l < NC; l++) set_hit(l, 32'hB0 + l, 32'h00FF_FFFF);
    #1;
    check("t4_grant0", core_hit_ready, 4'b0001);
    step_cores();
    #1;
    check("t4_grant1", core_hit_ready, 4'b0010);
    step_cores();
    #1;
    check("t4_full_hold", core_hit_ready, 4'b0000);
    check("t4_head0", gn_nonce, 32'hB0);
    step_cores();
    #1;
    check("t4_full_hold2", core_hit_ready, 4'b0000);
    check("t4_held", core_hit_valid, 4'b1100);
    gn_ready = 1'b1;
    #1;
    check("t4_grant2", core_hit_ready, 4'b0100);
    check("t4_pop0", gn_nonce, 32'hB0);
    check("t4_pop0_core", gn_core, 2'd0);
    step_cores();
    #1;
    check("t4_grant3", core_hit_ready, 4'b1000);
    check("t4_pop1", gn_nonce, 32'hB1);
    check("t4_pop1_core", gn_core, 2'd1);
    step_cores();
    #1;
    check("t4_pop2", gn_nonce, 32'hB2);
    check("t4_pop2_core", gn_core, 2'd2);
    step_cores();
    #1;
    check("t4_pop3", gn_nonce, 32'hB3);
    check("t4_pop3_core", gn_core, 2'd3);
    step_cores();
    gn_ready = 1'b0;
    check("t4_empty", gn_valid, 1'b0);
    check("t4_all_taken", core_hit_valid, 4'b0000);
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;

    // Stop on first qualifying hit at the third issue
    start_job(32'h0, 32'hFFFF, 6'd4, 1'b1);
    tick(); tick(); tick(); tick();
    check("t5_issue3", core_nonce_valid, 4'hF);
    check("t5_issue3_lane0", lane_n(0), 32'h8);
    set_hit(0, 32'h8, 32'h0FFF_FFFF);
    #1;
    check("t5_ready", core_hit_ready, 4'b0001);
    step_cores();
    any_issue = 1'b0;
    for (int i = 0; i < 6; i++) begin
      any_issue = any_issue | (|core_nonce_valid);
      tick();
    end
    check("t5_no_issue", any_issue, 1'b0);
    wait_done("t5_done", 100);
    check("t5_hashes", hashes_issued, 32'd12);
    check("t5_gn_nonce", gn_nonce, 32'h8);

    // Abort keeps the FIFO and allows an immediate new job
    start_job(32'h0, 32'hFFFF, 6'd40, 1'b0);
    tick(); tick();
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    check("t6_idle", busy, 1'b0);
    check("t6_job_ready", job_ready, 1'b1);
    check("t6_no_done", job_done, 1'b0);
    check("t6_no_issue", core_nonce_valid, 4'h0);
    check("t6_fifo_kept", gn_valid, 1'b1);
    start_job(32'h100, 32'hFFFF, 6'd40, 1'b0);
    check("t6_new_busy", busy, 1'b1);
    check("t6_new_valid", core_nonce_valid, 4'hF);
    check("t6_new_lane3", lane_n(3), 32'h103);
    check("t6_no_done2", job_done, 1'b0);
    set_hit(0, 32'h55, 32'h0000_0001);
    #1;
    check("t6_drop_ready", core_hit_ready, 4'b0001);
    step_cores();
    tick();
    check("t6_head", gn_nonce, 32'h8);
    gn_ready = 1'b1;
    tick();
    gn_ready = 1'b0;
    check("t6_clamped_drop", gn_valid, 1'b0);
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    check("t6_end_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
